// File: rtl/ctrl_fsm_gen_if.sv
// ctrl_fsm_gen_if: controller <-> datapath signal bundle.
// master = controller side (drives PCINC/D_W/ALU_SEL/B_SEL/REG_LOAD/
//   FINISH/ILLEGAL[/INSTR_CNT]); slave = datapath/memory side
//   (drives IR/Z/IMEM_RDY/DMEM_RDY/START).
// Optional INSTR_CNT member present when CTRL_INSTR_CNT_EN is defined.
interface ctrl_fsm_gen_if #(
  parameter int NREG   = 4,
  parameter int BSEL_W = 5,
  parameter int LOAD_W = NREG + 4
);
  logic [7:0]        IR;
  logic              Z;
  logic              IMEM_RDY;
  logic              DMEM_RDY;
  logic              START;
  logic              PCINC;
  logic              D_W;
  logic [3:0]        ALU_SEL;
  logic [BSEL_W-1:0] B_SEL;
  logic [LOAD_W-1:0] REG_LOAD;
  logic              FINISH;
  logic              ILLEGAL;
`ifdef CTRL_INSTR_CNT_EN
  logic [15:0]       INSTR_CNT;
`endif

  modport master (
    input  IR, Z, IMEM_RDY, DMEM_RDY, START,
    output PCINC, D_W, ALU_SEL, B_SEL, REG_LOAD,
`ifdef CTRL_INSTR_CNT_EN
    output INSTR_CNT,
`endif
    output FINISH, ILLEGAL
  );

  modport slave (
    output IR, Z, IMEM_RDY, DMEM_RDY, START,
    input  PCINC, D_W, ALU_SEL, B_SEL, REG_LOAD,
`ifdef CTRL_INSTR_CNT_EN
    input  INSTR_CNT,
`endif
    input  FINISH, ILLEGAL
  );
endinterface

// File: rtl/ctrl_fsm_gen.sv
// ctrl_fsm_gen: multi-cycle control unit for the accumulator processor.
// Ports: CLK, RESET (async, active-high), bus (ctrl_fsm_gen_if.master):
//   in  IR, Z, IMEM_RDY, DMEM_RDY, START
//   out PCINC, D_W, ALU_SEL, B_SEL, REG_LOAD, FINISH, ILLEGAL
// Optional: define CTRL_INSTR_CNT_EN to add the 16-bit saturating
//   retired-instruction counter on bus.INSTR_CNT.
module ctrl_fsm_gen #(
  parameter int NREG   = 4,
  parameter int BSEL_W = 5
) (
  input logic             CLK,
  input logic             RESET,
  ctrl_fsm_gen_if.master  bus
);

  localparam int LOAD_W = NREG + 4;

  typedef enum logic [3:0] {
    S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
    S_EXEC,   S_LD1,    S_LD2,    S_ST1,
    S_JN1,    S_JT1,    S_JT2,    S_JT3,
    S_END1,   S_END2,   S_HALT
  } state_t;

  state_t state_q, state_d;

  logic [3:0] cls;
  logic [3:0] idx;
  logic       reg_op;
  logic       reg_ok;
  logic       illegal;
  logic       taken;

  assign cls    = bus.IR[7:4];
  assign idx    = bus.IR[3:0];
  assign reg_op = (cls >= 4'h3) && (cls <= 4'h9);
  assign reg_ok = int'(idx) < NREG;
  assign illegal = (reg_op && !reg_ok) ||
                   (cls == 4'hF && idx != 4'h0 && idx != 4'hF);
  // JMPZ takes on Z=1, JMPNZ on Z=0; only consulted in DECODE
  assign taken  = (cls == 4'hD) ? bus.Z : !bus.Z;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH1: if (bus.IMEM_RDY) state_d = S_FETCH2;
      S_FETCH2: state_d = S_FETCH3;
      S_FETCH3: state_d = S_DECODE;
      S_DECODE: begin
        if (illegal) begin
          state_d = S_FETCH1;
        end else begin
          unique case (cls)
            4'h0:       state_d = S_FETCH1;
            4'h1:       state_d = S_LD1;
            4'h2:       state_d = S_ST1;
            4'hD, 4'hE: state_d = taken ? S_JT1 : S_JN1;
            4'hF:       state_d = (idx == 4'hF) ? S_END1 : S_EXEC;
            default:    state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC:   state_d = S_FETCH1;
      S_LD1:    if (bus.DMEM_RDY) state_d = S_LD2;
      S_LD2:    state_d = S_FETCH1;
      S_ST1:    if (bus.DMEM_RDY) state_d = S_FETCH1;
      S_JN1:    state_d = S_FETCH1;
      S_JT1:    state_d = S_JT2;
      S_JT2:    if (bus.IMEM_RDY) state_d = S_JT3;
      S_JT3:    state_d = S_FETCH1;
      S_END1:   state_d = S_END2;
      S_END2:   state_d = S_HALT;
      S_HALT:   if (bus.START) state_d = S_FETCH1;
      default:  state_d = S_FETCH1;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state_q <= S_FETCH1;
    else       state_q <= state_d;
  end

  logic              pcinc;
  logic              d_w;
  logic [3:0]        alu_sel;
  logic [BSEL_W-1:0] b_sel;
  logic [LOAD_W-1:0] reg_load;
  logic              finish;
  logic              ill_o;

  // Outputs decode the live state so an async reset drops D_W at once
  always_comb begin
    pcinc    = 1'b0;
    d_w      = 1'b0;
    alu_sel  = 4'd0;
    b_sel    = BSEL_W'(1);
    reg_load = '0;
    finish   = 1'b0;
    ill_o    = 1'b0;
    unique case (state_q)
      S_FETCH2: reg_load = LOAD_W'(8);
      S_FETCH3: pcinc = 1'b1;
      S_DECODE: ill_o = illegal;
      S_EXEC: begin
        unique case (cls)
          4'h3: begin
            b_sel    = BSEL_W'(2);
            reg_load = LOAD_W'(1) << (4 + idx);
          end
          4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
            b_sel    = BSEL_W'(3) + BSEL_W'(idx);
            reg_load = LOAD_W'(2);
            unique case (cls)
              4'h4:    alu_sel = 4'd1;
              4'h5:    alu_sel = 4'd2;
              4'h6:    alu_sel = 4'd3;
              4'h7:    alu_sel = 4'd9;
              4'h8:    alu_sel = 4'd10;
              default: alu_sel = 4'd11;
            endcase
          end
          4'hA: begin
            alu_sel  = 4'd12;
            reg_load = LOAD_W'(2);
          end
          4'hB: begin
            alu_sel  = 4'd4;
            reg_load = LOAD_W'(2);
          end
          4'hC: begin
            alu_sel  = 4'd5;
            reg_load = LOAD_W'(2);
          end
          4'hF: begin
            b_sel    = BSEL_W'(2);
            reg_load = LOAD_W'(1);
          end
          default: ;
        endcase
      end
      S_LD1: b_sel = BSEL_W'(0);
      S_LD2: begin
        alu_sel  = 4'd1;
        b_sel    = BSEL_W'(0);
        reg_load = LOAD_W'(2);
      end
      S_ST1: begin
        d_w   = 1'b1;
        b_sel = BSEL_W'(2);
      end
      S_JN1: pcinc = 1'b1;
      S_JT1: pcinc = 1'b1;
      S_JT3: reg_load = LOAD_W'(4);
      S_END1: begin
        alu_sel  = 4'd5;
        reg_load = LOAD_W'(2);
      end
      // AC is zero after END1, so PC <- AC clears the PC
      S_END2: begin
        b_sel    = BSEL_W'(2);
        reg_load = LOAD_W'(4);
      end
      S_HALT: finish = 1'b1;
      default: ;
    endcase
  end

  assign bus.PCINC    = pcinc;
  assign bus.D_W      = d_w;
  assign bus.ALU_SEL  = alu_sel;
  assign bus.B_SEL    = b_sel;
  assign bus.REG_LOAD = reg_load;
  assign bus.FINISH   = finish;
  assign bus.ILLEGAL  = ill_o;

`ifdef CTRL_INSTR_CNT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        retire;

  // DECODE -> FETCH1 only happens for NOP or an illegal opcode
  assign retire = (state_d == S_FETCH1) &&
                  (state_q inside {S_DECODE, S_EXEC, S_LD2,
                                   S_ST1, S_JN1, S_JT3});

  always_comb begin
    cnt_d = cnt_q;
    if (retire && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) cnt_q <= 16'd0;
    else       cnt_q <= cnt_d;
  end

  assign bus.INSTR_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_ctrl_fsm_gen.sv
// tb_ctrl_fsm_gen: random instruction stream vs an instruction-level
// model of the expected per-cycle control outputs.
module tb_ctrl_fsm_gen;

  localparam int NREG   = 4;
  localparam int BSEL_W = 5;

  logic CLK   = 1'b0;
  logic RESET = 1'b1;
  always #5 CLK = ~CLK;

  ctrl_fsm_gen_if #(.NREG(NREG), .BSEL_W(BSEL_W)) bus ();

  ctrl_fsm_gen #(.NREG(NREG), .BSEL_W(BSEL_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int icnt  = 0;

  // ALU code per opcode class for the single-cycle ops
  int alu_tab [16] = '{0, 0, 0, 0, 1, 2, 3, 9,
                       10, 11, 12, 4, 5, 0, 0, 0};

  function automatic logic [31:0] pk(int pc, int dw, int alu,
                                     int bs, int ld,
                                     int fin = 0, int ill = 0);
    logic [31:0] v;
    v = {11'b0, pc[0], dw[0], alu[3:0], bs[4:0], ld[7:0],
         fin[0], ill[0]};
    return v;
  endfunction

  function automatic logic [31:0] obs();
    return {11'b0, bus.PCINC, bus.D_W, bus.ALU_SEL, bus.B_SEL,
            bus.REG_LOAD, bus.FINISH, bus.ILLEGAL};
  endfunction

  function automatic bit rb();
    return bit'($urandom % 2);
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // one clock cycle: drive, check mid-cycle, advance past next edge
  task automatic step(string tag, logic [31:0] e,
                      bit im, bit dm, bit z, bit st);
    bus.IMEM_RDY = im;
    bus.DMEM_RDY = dm;
    bus.Z        = z;
    bus.START    = st;
    @(negedge CLK);
    chk(tag, obs(), e);
    @(posedge CLK);
    #1;
  endtask

  task automatic retire();
    if (icnt < 65535) icnt++;
  endtask

  task automatic run_instr(logic [7:0] ir, bit zf);
    int cls, n, ill, stall, ld, bs;
    bit tk;
    cls = int'(ir[7:4]);
    n   = int'(ir[3:0]);
    ill = ((cls >= 3 && cls <= 9 && n >= NREG) ||
           (cls == 15 && n != 0 && n != 15)) ? 1 : 0;
    bus.IR = ir;
`ifdef CTRL_INSTR_CNT_EN
    chk("instr_cnt", {16'b0, bus.INSTR_CNT}, icnt);
`endif
    stall = $urandom_range(0, 3);
    for (int k = 0; k < stall; k++)
      step("fetch1_wait", pk(0, 0, 0, 1, 0), 0, rb(), rb(), rb());
    step("fetch1", pk(0, 0, 0, 1, 0), 1, rb(), rb(), rb());
    step("fetch2", pk(0, 0, 0, 1, 8), rb(), rb(), rb(), rb());
    step("fetch3", pk(1, 0, 0, 1, 0), rb(), rb(), rb(), rb());
    step("decode", pk(0, 0, 0, 1, 0, 0, ill), rb(), rb(), zf, rb());
    if (ill == 1 || cls == 0) begin
      retire();
      return;
    end
    if (cls == 1) begin
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++)
        step("ld1_wait", pk(0, 0, 0, 0, 0), rb(), 0, rb(), rb());
      step("ld1", pk(0, 0, 0, 0, 0), rb(), 1, rb(), rb());
      step("ld2", pk(0, 0, 1, 0, 2), rb(), rb(), rb(), rb());
      retire();
    end else if (cls == 2) begin
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++)
        step("st1_wait", pk(0, 1, 0, 2, 0), rb(), 0, rb(), rb());
      step("st1", pk(0, 1, 0, 2, 0), rb(), 1, rb(), rb());
      retire();
    end else if (cls == 13 || cls == 14) begin
      tk = (cls == 13) ? zf : !zf;
      if (!tk) begin
        step("jn1", pk(1, 0, 0, 1, 0), rb(), rb(), rb(), rb());
      end else begin
        step("jt1", pk(1, 0, 0, 1, 0), rb(), rb(), rb(), rb());
        stall = $urandom_range(0, 3);
        for (int k = 0; k < stall; k++)
          step("jt2_wait", pk(0, 0, 0, 1, 0), 0, rb(), rb(), rb());
        step("jt2", pk(0, 0, 0, 1, 0), 1, rb(), rb(), rb());
        step("jt3", pk(0, 0, 0, 1, 4), rb(), rb(), rb(), rb());
      end
      retire();
    end else if (cls == 15 && n == 15) begin
      step("end1", pk(0, 0, 5, 1, 2), rb(), rb(), rb(), rb());
      step("end2", pk(0, 0, 0, 2, 4), rb(), rb(), rb(), rb());
      stall = $urandom_range(0, 3);
      for (int k = 0; k < stall; k++)
        step("halt_wait", pk(0, 0, 0, 1, 0, 1), rb(), rb(), rb(), 0);
      step("halt", pk(0, 0, 0, 1, 0, 1), rb(), rb(), rb(), 1);
    end else begin
      if (cls == 3)       ld = 1 << (4 + n);
      else if (cls == 15) ld = 1;
      else                ld = 2;
      if (cls >= 4 && cls <= 9)       bs = 3 + n;
      else if (cls == 3 || cls == 15) bs = 2;
      else                            bs = 1;
      step("exec", pk(0, 0, alu_tab[cls], bs, ld),
           rb(), rb(), rb(), rb());
      retire();
    end
  endtask

  task automatic rst_in_st1();
    bus.IR = 8'h20;
    step("f1_st", pk(0, 0, 0, 1, 0), 1, 0, 0, 0);
    step("f2_st", pk(0, 0, 0, 1, 8), 0, 0, 0, 0);
    step("f3_st", pk(1, 0, 0, 1, 0), 0, 0, 0, 0);
    step("dec_st", pk(0, 0, 0, 1, 0), 0, 0, 0, 0);
    bus.DMEM_RDY = 1'b0;
    bus.IMEM_RDY = 1'b0;
    #2;
    chk("st1_before_rst", obs(), pk(0, 1, 0, 2, 0));
    RESET = 1'b1;
    #1;
    chk("rst_abort_st1", obs(), pk(0, 0, 0, 1, 0));
    @(negedge CLK);
    RESET = 1'b0;
    @(posedge CLK);
    #1;
    icnt = 0;
  endtask

  initial begin
    bus.IR       = 8'h00;
    bus.Z        = 1'b0;
    bus.IMEM_RDY = 1'b0;
    bus.DMEM_RDY = 1'b0;
    bus.START    = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_state", obs(), pk(0, 0, 0, 1, 0));
    RESET = 1'b0;
    @(posedge CLK);
    #1;

    run_instr(8'h52, 1'b0);
    run_instr(8'h10, 1'b0);
    run_instr(8'hD0, 1'b1);
    run_instr(8'hD0, 1'b0);
    run_instr(8'hE3, 1'b0);
    run_instr(8'h36, 1'b0);
    run_instr(8'h32, 1'b0);
    run_instr(8'hF0, 1'b0);
    run_instr(8'hF5, 1'b0);
    run_instr(8'hFF, 1'b0);
    run_instr(8'h00, 1'b0);
    rst_in_st1();
    run_instr(8'h4F, 1'b1);
    run_instr(8'h93, 1'b0);

    repeat (400) run_instr(8'($urandom), rb());

`ifdef CTRL_INSTR_CNT_EN
    chk("instr_cnt_final", {16'b0, bus.INSTR_CNT}, icnt);
`endif
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
